// File: rtl/host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : host_cmd_master
// Brief   : Runs host register read/write commands as state-coded, strobed
//           phases on a device bus, with a bounded wait for read data.
// Rev     : 1.0  initial release
// ============================================================================
module host_cmd_master #(
    parameter int SETTLE  = 3,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        if_clock,
    input  logic        resetb,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdRead,
    input  logic [15:0] cmdEpAddr,
    input  logic [15:0] cmdRegAddr,
    input  logic [15:0] cmdData,
    output logic        rspValid,
    output logic [15:0] rspData,
    output logic        rspTimeout,
    output logic        busy,
    output logic [3:0]  state,
    output logic [2:0]  ctl,
    input  logic        rdy,
    output logic [15:0] dataOut,
    output logic        dataOe,
    input  logic [15:0] dataIn
);

    localparam int c_cnt_w = $clog2(((SETTLE > HOLD) ? SETTLE : HOLD) + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last    = c_tmo_w'(TIMEOUT - 1);

    localparam logic [1:0] c_ph_ep   = 2'd0;
    localparam logic [1:0] c_ph_reg  = 2'd1;
    localparam logic [1:0] c_ph_last = 2'd2;

    localparam logic [3:0] c_code_idle    = 4'b0000;
    localparam logic [3:0] c_code_setep   = 4'b0001;
    localparam logic [3:0] c_code_setreg  = 4'b0010;
    localparam logic [3:0] c_code_setrval = 4'b0011;
    localparam logic [3:0] c_code_rddata  = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_STROBE   = 3'd2,
        S_RD_PULSE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RESP     = 3'd5
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [1:0]         r_phase;
    logic [1:0]         w_phase_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_tmo_w-1:0] r_tmo;
    logic [c_tmo_w-1:0] w_tmo_nxt;
    logic               r_read;
    logic [15:0]        r_ep;
    logic [15:0]        r_reg;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rsp_data;
    logic [15:0]        w_rsp_data_nxt;
    logic               r_rsp_to;
    logic               w_rsp_to_nxt;
    logic               w_accept;
    logic [15:0]        w_phase_val;

    assign w_accept = (r_fsm == S_IDLE) && cmdValid;

    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb) begin
            r_phase    <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_read     <= 1'b0;
            r_ep       <= '0;
            r_reg      <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_to   <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmo      <= w_tmo_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rsp_to   <= w_rsp_to_nxt;
            if (w_accept) begin
                r_read  <= cmdRead;
                r_ep    <= cmdEpAddr;
                r_reg   <= cmdRegAddr;
                r_wdata <= cmdData;
            end
        end
    end

    always_comb begin
        w_fsm_nxt      = r_fsm;
        w_phase_nxt    = r_phase;
        w_cnt_nxt      = r_cnt;
        w_tmo_nxt      = r_tmo;
        w_rsp_data_nxt = r_rsp_data;
        w_rsp_to_nxt   = r_rsp_to;
        case (r_fsm)
            S_IDLE: begin
                if (cmdValid) begin
                    w_fsm_nxt   = S_SETTLE;
                    w_phase_nxt = c_ph_ep;
                    w_cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_cnt_nxt = '0;
                    w_fsm_nxt = (r_read && (r_phase == c_ph_last)) ? S_RD_PULSE : S_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STROBE: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt_nxt = '0;
                    if (r_phase == c_ph_last) begin
                        w_fsm_nxt      = S_RESP;
                        w_rsp_data_nxt = '0;
                        w_rsp_to_nxt   = 1'b0;
                    end else begin
                        // Next code follows the strobe directly, no IDLE code in between.
                        w_fsm_nxt   = S_SETTLE;
                        w_phase_nxt = r_phase + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_PULSE: begin
                w_fsm_nxt = S_RD_WAIT;
                w_tmo_nxt = '0;
            end
            S_RD_WAIT: begin
                // rdy on the final count still wins over the timeout.
                if (rdy) begin
                    w_fsm_nxt      = S_RESP;
                    w_rsp_data_nxt = dataIn;
                    w_rsp_to_nxt   = 1'b0;
                end else if (r_tmo == c_tmo_last) begin
                    w_fsm_nxt      = S_RESP;
                    w_rsp_data_nxt = '0;
                    w_rsp_to_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_RESP: begin
                w_fsm_nxt = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (r_phase)
            c_ph_ep:  w_phase_val = r_ep;
            c_ph_reg: w_phase_val = r_reg;
            default:  w_phase_val = r_wdata;
        endcase
    end

    always_comb begin
        state   = c_code_idle;
        ctl     = 3'b000;
        dataOe  = 1'b0;
        dataOut = '0;
        if ((r_fsm == S_SETTLE) || (r_fsm == S_STROBE) ||
            (r_fsm == S_RD_PULSE) || (r_fsm == S_RD_WAIT)) begin
            case (r_phase)
                c_ph_ep:  state = c_code_setep;
                c_ph_reg: state = c_code_setreg;
                default:  state = r_read ? c_code_rddata : c_code_setrval;
            endcase
        end
        if (r_fsm == S_STROBE) begin
            ctl[1]  = 1'b1;
            dataOe  = 1'b1;
            dataOut = w_phase_val;
        end
        if (r_fsm == S_RD_PULSE) begin
            ctl[1] = 1'b1;
        end
    end

    assign cmdReady   = (r_fsm == S_IDLE);
    assign busy       = ~cmdReady;
    assign rspValid   = (r_fsm == S_RESP);
    assign rspData    = r_rsp_data;
    assign rspTimeout = r_rsp_to;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_host_cmd_master
// Brief   : Self-checking bench for host_cmd_master: command vector table plus
//           directed back-to-back, reset-abort and hold sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_host_cmd_master;

    localparam int SETTLE  = 3;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 16;
    localparam int NVEC    = 10;

    logic        if_clock   = 1'b0;
    logic        resetb     = 1'b1;
    logic        cmdValid   = 1'b0;
    logic        cmdRead    = 1'b0;
    logic [15:0] cmdEpAddr  = '0;
    logic [15:0] cmdRegAddr = '0;
    logic [15:0] cmdData    = '0;
    logic        rdy        = 1'b0;
    logic [15:0] dataIn     = 16'hDEAD;
    logic        cmdReady;
    logic        rspValid;
    logic [15:0] rspData;
    logic        rspTimeout;
    logic        busy;
    logic [3:0]  state;
    logic [2:0]  ctl;
    logic [15:0] dataOut;
    logic        dataOe;

    host_cmd_master #(.SETTLE(SETTLE), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) u_dut (
        .if_clock  (if_clock),
        .resetb    (resetb),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdRead   (cmdRead),
        .cmdEpAddr (cmdEpAddr),
        .cmdRegAddr(cmdRegAddr),
        .cmdData   (cmdData),
        .rspValid  (rspValid),
        .rspData   (rspData),
        .rspTimeout(rspTimeout),
        .busy      (busy),
        .state     (state),
        .ctl       (ctl),
        .rdy       (rdy),
        .dataOut   (dataOut),
        .dataOe    (dataOe),
        .dataIn    (dataIn)
    );

    always #5 if_clock = ~if_clock;

    // ---------------- bus monitor ----------------
    int          cyc = 0, acc_cyc = 0, acc_gap = 0, rsp_cyc = 0;
    int          n_acc = 0, n_rsp = 0, last_lat = 0, n_rdpulse = 0, n_txn = 0, n_viol = 0, since = 0;
    logic [15:0] last_data = '0;
    logic        last_to = 1'b0;
    logic [3:0]  prev_state = '0;
    logic        prev_ctl1 = 1'b0, prev_rspv = 1'b0;
    logic [3:0]  st_log[$];
    logic [19:0] sb_log[$];
    logic        viol;
    int          since_now;

    function automatic bit legal(input logic [3:0] a, input logic [3:0] b);
        return (a == 4'd0 && b == 4'd1) || (a == 4'd1 && b == 4'd2) ||
               (a == 4'd2 && (b == 4'd3 || b == 4'd4)) ||
               ((a == 4'd3 || a == 4'd4) && b == 4'd0);
    endfunction

    always_comb begin
        since_now = (state != prev_state) ? 0 : since + 1;
        viol = 1'b0;
        if (ctl[0] || ctl[2]) viol = 1'b1;
        if (busy == cmdReady) viol = 1'b1;
        if (!dataOe && dataOut != 16'h0) viol = 1'b1;
        if (dataOe && !(state == 4'd1 || state == 4'd2 || state == 4'd3)) viol = 1'b1;
        if ((state == 4'd1 || state == 4'd2 || state == 4'd3) && (ctl[1] != dataOe)) viol = 1'b1;
        if (ctl[1] && since_now < SETTLE) viol = 1'b1;
        if (rspValid && (state != 4'd0 || ctl != 3'd0 || prev_rspv)) viol = 1'b1;
        if (resetb && state != prev_state && !legal(prev_state, state)) viol = 1'b1;
    end

    always @(posedge if_clock) cyc <= cyc + 1;

    always @(negedge if_clock) begin
        prev_state <= state;
        prev_ctl1  <= ctl[1];
        prev_rspv  <= rspValid;
        since      <= since_now;
        if (state != prev_state) st_log.push_back(state);
        if (dataOe) sb_log.push_back({state, dataOut});
        if (cmdValid && cmdReady) begin
            acc_cyc <= cyc + 1;
            acc_gap <= cyc + 1 - rsp_cyc;
            n_acc   <= n_acc + 1;
        end
        if (rspValid) begin
            n_rsp     <= n_rsp + 1;
            rsp_cyc   <= cyc;
            last_lat  <= cyc - acc_cyc + 1;
            last_data <= rspData;
            last_to   <= rspTimeout;
        end
        if (state == 4'd4 && ctl[1]) n_rdpulse <= n_rdpulse + 1;
        if (ctl[1] && !prev_ctl1 && (state == 4'd3 || state == 4'd4)) n_txn <= n_txn + 1;
        if (viol) n_viol <= n_viol + 1;
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input bit rd, input logic [15:0] ep, input logic [15:0] rg, input logic [15:0] wd);
        @(posedge if_clock); #1;
        cmdValid = 1'b1; cmdRead = rd; cmdEpAddr = ep; cmdRegAddr = rg; cmdData = wd;
        @(posedge if_clock); #1;
        cmdValid = 1'b0; cmdRead = ~rd;
        cmdEpAddr = 16'h5555; cmdRegAddr = 16'h6666; cmdData = 16'h7777;
    endtask

    // Acts as the device for reads, then waits for the response pulse.
    task automatic finish_cmd(input bit rd, input bit spam, input int dly, input logic [15:0] dev, input int rsp0);
        int i;
        if (spam) begin
            repeat (2) begin
                rdy = 1'b1; dataIn = 16'hC0DE;
                @(posedge if_clock); #1;
                rdy = 1'b0; dataIn = 16'hDEAD;
                @(posedge if_clock); #1;
            end
        end
        if (rd && dly > 0) begin
            i = 0;
            while (i < 64 && !(state == 4'd4 && ctl[1])) begin
                @(negedge if_clock);
                i++;
            end
            check("rd_pulse_seen", (i < 64), 1);
            repeat (dly) @(negedge if_clock);
            rdy = 1'b1; dataIn = dev;
            @(negedge if_clock);
            rdy = 1'b0; dataIn = 16'hDEAD;
        end
        i = 0;
        while (i < 200 && n_rsp == rsp0) begin
            @(negedge if_clock); #1;
            i++;
        end
        check("rsp_count", n_rsp - rsp0, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rd;
        bit          spam;
        logic [15:0] ep;
        logic [15:0] rg;
        logic [15:0] wd;
        int          dly;
        logic [15:0] dev;
        logic [15:0] exp_data;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[NVEC];
    int          st0, sb0, rp0, tx0, vi0, r0, a0, n_exp_sb, k;
    logic [3:0]  exp_st[8];
    logic [19:0] exp_sb[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           rd    spam  ep        rg        wd        dly dev       exp_data  to    lat
        vecs[0] = '{1'b0, 1'b0, 16'h0002, 16'h0010, 16'hBEEF, 0,  16'h0000, 16'h0000, 1'b0, 16};
        vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 0,  16'h0000, 16'h0000, 1'b0, 16};
        vecs[2] = '{1'b0, 1'b0, 16'h1234, 16'hABCD, 16'h5A5A, 0,  16'h0000, 16'h0000, 1'b0, 16};
        vecs[3] = '{1'b1, 1'b0, 16'h0002, 16'h0010, 16'h0000, 5,  16'h1234, 16'h1234, 1'b0, 20};
        vecs[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0F0F, 16'h0000, 1,  16'hA5A5, 16'hA5A5, 1'b0, 16};
        vecs[5] = '{1'b1, 1'b0, 16'h0001, 16'h0002, 16'h0000, 15, 16'h0F0F, 16'h0F0F, 1'b0, 30};
        vecs[6] = '{1'b1, 1'b0, 16'h0003, 16'h0004, 16'h0000, 16, 16'hC3C3, 16'hC3C3, 1'b0, 31};
        vecs[7] = '{1'b1, 1'b0, 16'h0005, 16'h0006, 16'h0000, 0,  16'h0000, 16'h0000, 1'b1, 31};
        vecs[8] = '{1'b0, 1'b0, 16'h0007, 16'h0008, 16'hFACE, 0,  16'h0000, 16'h0000, 1'b0, 16};
        vecs[9] = '{1'b1, 1'b1, 16'h0009, 16'h000A, 16'h0000, 3,  16'h7E57, 16'h7E57, 1'b0, 18};

        // Reset state
        #1 resetb = 1'b0;
        #1;
        check("rst_state", state, 4'h0);
        check("rst_ctl", ctl, 3'h0);
        check("rst_dataOe", dataOe, 1'b0);
        check("rst_dataOut", dataOut, 16'h0);
        check("rst_rspValid", rspValid, 1'b0);
        check("rst_rspData", rspData, 16'h0);
        check("rst_rspTimeout", rspTimeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmdReady", cmdReady, 1'b1);
        repeat (2) @(posedge if_clock);
        #1 resetb = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            st0 = st_log.size(); sb0 = sb_log.size();
            rp0 = n_rdpulse; vi0 = n_viol; r0 = n_rsp;
            issue_cmd(vecs[v].rd, vecs[v].ep, vecs[v].rg, vecs[v].wd);
            if (v > 0) begin
                check($sformatf("v%0d_hold_data", v), rspData, vecs[v-1].exp_data);
                check($sformatf("v%0d_hold_to", v), rspTimeout, vecs[v-1].exp_to);
            end
            finish_cmd(vecs[v].rd, vecs[v].spam, vecs[v].dly, vecs[v].dev, r0);
            check($sformatf("v%0d_latency", v), last_lat, vecs[v].exp_lat);
            check($sformatf("v%0d_rspData", v), last_data, vecs[v].exp_data);
            check($sformatf("v%0d_rspTimeout", v), last_to, vecs[v].exp_to);
            check($sformatf("v%0d_rspData_held", v), rspData, vecs[v].exp_data);

            exp_st[0] = 4'h1; exp_st[1] = 4'h2;
            exp_st[2] = vecs[v].rd ? 4'h4 : 4'h3; exp_st[3] = 4'h0;
            check($sformatf("v%0d_state_len", v), st_log.size() - st0, 4);
            for (k = 0; k < 4; k++)
                check($sformatf("v%0d_state%0d", v, k),
                      (st0 + k < st_log.size()) ? st_log[st0 + k] : 4'hF, exp_st[k]);

            exp_sb[0] = {4'h1, vecs[v].ep}; exp_sb[1] = {4'h1, vecs[v].ep};
            exp_sb[2] = {4'h2, vecs[v].rg}; exp_sb[3] = {4'h2, vecs[v].rg};
            exp_sb[4] = {4'h3, vecs[v].wd}; exp_sb[5] = {4'h3, vecs[v].wd};
            n_exp_sb = vecs[v].rd ? 4 : 6;
            check($sformatf("v%0d_strobe_len", v), sb_log.size() - sb0, n_exp_sb);
            for (k = 0; k < n_exp_sb; k++)
                check($sformatf("v%0d_strobe%0d", v, k),
                      (sb0 + k < sb_log.size()) ? sb_log[sb0 + k] : 20'hFFFFF, exp_sb[k]);

            check($sformatf("v%0d_rd_pulses", v), n_rdpulse - rp0, vecs[v].rd ? 1 : 0);
            check($sformatf("v%0d_protocol", v), n_viol - vi0, 0);
        end

        // rdy/dataIn toggling while idle must not disturb the held response
        r0 = n_rsp;
        issue_cmd(1'b1, 16'h0011, 16'h0022, 16'h0000);
        finish_cmd(1'b1, 1'b0, 2, 16'h4321, r0);
        @(posedge if_clock); #1;
        rdy = 1'b1; dataIn = 16'hFFFF;
        repeat (2) @(posedge if_clock);
        #1 rdy = 1'b0; dataIn = 16'hDEAD;
        repeat (3) @(posedge if_clock);
        #1;
        check("idle_rdy_rspData", rspData, 16'h4321);
        check("idle_rdy_rspTimeout", rspTimeout, 1'b0);
        check("idle_rdy_no_rsp", n_rsp - r0, 1);
        check("idle_rdy_ready", cmdReady, 1'b1);

        // Back-to-back with cmdValid held high
        st0 = st_log.size(); sb0 = sb_log.size();
        tx0 = n_txn; vi0 = n_viol; r0 = n_rsp; a0 = n_acc;
        @(posedge if_clock); #1;
        cmdValid = 1'b1; cmdRead = 1'b0;
        cmdEpAddr = 16'h00A1; cmdRegAddr = 16'h00B1; cmdData = 16'h1111;
        @(posedge if_clock); #1;
        cmdEpAddr = 16'h00A2; cmdRegAddr = 16'h00B2; cmdData = 16'h2222;
        k = 0;
        while (k < 100 && n_acc - a0 < 2) begin
            @(negedge if_clock); #1;
            k++;
        end
        check("b2b_first_rsp_before_second", n_rsp - r0, 1);
        @(posedge if_clock); #1;
        cmdValid = 1'b0;
        k = 0;
        while (k < 100 && n_rsp - r0 < 2) begin
            @(negedge if_clock); #1;
            k++;
        end
        check("b2b_accepts", n_acc - a0, 2);
        check("b2b_rsps", n_rsp - r0, 2);
        check("b2b_accept_gap", acc_gap, 2);
        check("b2b_latency2", last_lat, 16);
        check("b2b_device_txns", n_txn - tx0, 2);
        check("b2b_state_len", st_log.size() - st0, 8);
        check("b2b_state7", (st0 + 7 < st_log.size()) ? st_log[st0 + 7] : 4'hF, 4'h0);
        check("b2b_strobe_len", sb_log.size() - sb0, 12);
        check("b2b_strobe_a", (sb0 + 4 < sb_log.size()) ? sb_log[sb0 + 4] : 20'hFFFFF, {4'h3, 16'h1111});
        check("b2b_strobe_b", (sb0 + 11 < sb_log.size()) ? sb_log[sb0 + 11] : 20'hFFFFF, {4'h3, 16'h2222});
        check("b2b_protocol", n_viol - vi0, 0);

        // Reset pulsed during the SETREG strobe
        r0 = n_rsp;
        issue_cmd(1'b0, 16'h1111, 16'h2222, 16'h3333);
        k = 0;
        while (k < 64 && !(state == 4'd2 && ctl[1])) begin
            @(negedge if_clock);
            k++;
        end
        check("abort_strobe_seen", (k < 64), 1);
        #2 resetb = 1'b0;
        #1;
        check("abort_state", state, 4'h0);
        check("abort_ctl", ctl, 3'h0);
        check("abort_dataOe", dataOe, 1'b0);
        check("abort_dataOut", dataOut, 16'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_cmdReady", cmdReady, 1'b1);
        repeat (2) @(posedge if_clock);
        #1;
        resetb = 1'b1;
        cmdValid = 1'b1; cmdRead = 1'b0;
        cmdEpAddr = 16'h4444; cmdRegAddr = 16'h5555; cmdData = 16'h6666;
        @(posedge if_clock); #1;
        cmdValid = 1'b0;
        check("abort_first_edge_accept", busy, 1'b1);
        check("abort_no_rsp", n_rsp - r0, 0);
        sb0 = sb_log.size(); vi0 = n_viol;
        finish_cmd(1'b0, 1'b0, 0, 16'h0000, r0);
        check("abort_next_latency", last_lat, 16);
        check("abort_next_rspData", last_data, 16'h0000);
        check("abort_next_strobe_len", sb_log.size() - sb0, 6);
        check("abort_next_strobe_last", (sb0 + 5 < sb_log.size()) ? sb_log[sb0 + 5] : 20'hFFFFF, {4'h3, 16'h6666});
        check("abort_next_protocol", n_viol - vi0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/host_cmd_master.md
HOST_CMD_MASTER -- requirements
Module: host_cmd_master

Interface
REQ-001 The block SHALL have parameter SETTLE, default 3: cycles a new state code is held before ctl[1] may rise; legal range is 3 or more.
REQ-002 The block SHALL have parameter HOLD, default 2: cycles ctl[1] and dataOut are held for a write phase; legal range is 1 or more.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: the maximum number of cycles it waits for rdy in a read.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- if_clock  in  1  the single clock; all logic is on its rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- cmdValid  in  1  a command is presented.
- cmdReady  out  1  the block can accept a command.
- cmdRead  in  1  1 means register read, 0 means register write.
- cmdEpAddr  in  16  endpoint address.
- cmdRegAddr  in  16  register address.
- cmdData  in  16  write value.
- rspValid  out  1  one-cycle pulse marking command completion.
- rspData  out  16  read value.
- rspTimeout  out  1  qualifies rspValid; 1 means the read timed out.
- busy  out  1  a command is in progress.
- state  out  4  state code driven to the device.
- ctl  out  3  control lines; bit 1 is rdwr_b; bits 0 and 2 are held at 0.
- rdy  in  1  device data-valid.
- dataOut  out  16  bus value to drive.
- dataOe  out  1  bus drive enable; the board-level tristate is outside this block.
- dataIn  in  16  sampled bus value.

Function
REQ-005 State codes SHALL be: IDLE=0000, SETEP=0001, SETREG=0010, SETRVAL=0011, RDDATA=0100.
REQ-006 A command SHALL be accepted on a rising edge where cmdValid=1 and cmdReady=1; all cmd* fields are captured at that edge.
REQ-007 cmdReady SHALL equal 1 only in FSM state IDLE; cmdValid while not ready is ignored.
REQ-008 busy SHALL equal the inverse of cmdReady.
REQ-009 FSM states SHALL be IDLE, SETTLE, STROBE, RD_PULSE, RD_WAIT and RESP.
REQ-010 A write command SHALL run three phases in order: SETEP with cmdEpAddr, SETREG with cmdRegAddr, SETRVAL with cmdData.
REQ-011 A read command SHALL run three phases in order: SETEP, SETREG, RDDATA.
REQ-012 Each phase SHALL start by driving its state code, changing directly from the previous code with no IDLE code in between.
REQ-013 Each phase SHALL hold ctl[1]=0 for SETTLE cycles (SETTLE state) after the state code changes.
REQ-014 In a write phase, after settling, the STROBE state SHALL drive ctl[1]=1, dataOe=1 and dataOut=phase value for exactly HOLD cycles.
REQ-015 The next phase's state code SHALL be driven on the cycle after the last STROBE cycle; at that point ctl[1]=0 and dataOe=0.
REQ-016 dataOe SHALL be 1 only in STROBE; dataOut SHALL be 0 whenever dataOe=0.
REQ-017 In the RDDATA phase, after settling, RD_PULSE SHALL drive ctl[1]=1 for exactly one cycle, then enter RD_WAIT with ctl[1]=0.
REQ-018 dataOe SHALL be 0 throughout the RDDATA phase; a longer ctl[1] pulse retriggers the device read and is forbidden.
REQ-019 In RD_WAIT, on the first cycle with rdy=1, dataIn SHALL be captured into rspData and the FSM SHALL enter RESP.
REQ-020 RD_WAIT SHALL count cycles from 0; if the count reaches TIMEOUT-1 without rdy, the FSM SHALL set rspData=0 and rspTimeout=1 and enter RESP.
REQ-021 rdy=1 on the same cycle the count reaches TIMEOUT-1 SHALL count as success, not timeout.
REQ-022 The timeout counter SHALL be wide enough for TIMEOUT without wrap-around, and SHALL be cleared on entry to RD_WAIT.
REQ-023 RESP SHALL last one cycle: rspValid=1, state=IDLE, ctl=0; the FSM then returns to IDLE.
REQ-024 For a write, rspData=0 and rspTimeout=0 at the rspValid pulse.
REQ-025 rspData and rspTimeout SHALL hold until the next rspValid.
REQ-026 rdy and dataIn SHALL be ignored outside RD_WAIT.
REQ-027 Write latency SHALL be: accept at edge 0, first SETEP code at cycle 1, rspValid at cycle 3*(SETTLE+HOLD)+1; with defaults, rspValid is at cycle 16.
REQ-028 A new command SHALL be accepted no earlier than the cycle after rspValid.

Reset
REQ-029 While resetb=0, asynchronously: state=0000, ctl=000, dataOe=0, dataOut=0, rspValid=0, rspData=0, rspTimeout=0, busy=0, cmdReady=1, counters=0, FSM=IDLE.
REQ-030 Reset asserted mid-command SHALL abort the command with no rspValid; the first acceptance is possible on the first edge after resetb rises.

Verification
REQ-031 Write with ep=0x0002, reg=0x0010, data=0xBEEF and defaults -> state sequence 1,2,3,0; dataOe=1 with dataOut 0x0002, 0x0010, 0xBEEF for 2 cycles each; rspValid at cycle 16 with rspTimeout=0.
REQ-032 Read with a device model returning 0x1234 with rdy 5 cycles after the ctl[1] pulse -> exactly one ctl[1] pulse; dataOe=0 in RDDATA; rspData=0x1234; rspTimeout=0.
REQ-033 Read with rdy held at 0 and TIMEOUT=16 -> rspValid 16 cycles after entering RD_WAIT, rspTimeout=1, rspData=0, state returns to 0000.
REQ-034 cmdValid held high for back-to-back commands -> second command accepted only after rspValid; no state code glitch; device model records 2 transactions.
REQ-035 resetb pulsed low during the SETREG strobe -> all outputs 0 immediately, no rspValid, and the next command completes normally.
REQ-036 rdy pulses during the SETEP phase of a read -> ignored, and the read returns the correct value.
